sdf_bf_stage: RTL and testbench
===============================

SDF_BF_STAGE -- requirements
Module: sdf_bf_stage

Interface
REQ-001 Parameter WIDTH, default 13, SHALL set the input sample width per component (two's complement).
REQ-002 Parameter DEPTH_LOG2, default 3, SHALL set the feedback delay D = 2^DEPTH_LOG2 samples and the frame length 2D.
REQ-003 Parameter SCALE, default 0, SHALL select the output mode: 0 = full-precision growth bit, 1 = arithmetic right shift by 1.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit, SHALL qualify the input sample in the current cycle.
REQ-007 Port in_sof, input, 1 bit, SHALL mark the first sample of a frame; it is ignored unless in_valid=1.
REQ-008 Port in_re, input, WIDTH bits, SHALL carry the real part of the input sample.
REQ-009 Port in_im, input, WIDTH bits, SHALL carry the imaginary part of the input sample.
REQ-010 Port out_valid, output, 1 bit, SHALL be registered and qualify out_re/out_im.
REQ-011 Port out_sof, output, 1 bit, SHALL be registered and mark the first butterfly sum of a frame.
REQ-012 Port out_re, output, WIDTH+1 bits, SHALL carry the registered real result.
REQ-013 Port out_im, output, WIDTH+1 bits, SHALL carry the registered imaginary result.

Function
REQ-014 The block SHALL hold a sample counter cnt of DEPTH_LOG2+1 bits that advances only on cycles with in_valid=1, wrapping from 2D-1 to 0.
REQ-015 Phase SHALL equal the MSB of the effective count. Effective count = 0 when in_valid=1 and in_sof=1; otherwise it is cnt.
REQ-016 When in_sof=1 with in_valid=1, cnt SHALL be loaded with 1 (resync); delay-line contents SHALL NOT be cleared.
REQ-017 The delay line SHALL hold D complex entries of WIDTH+1 bits each, and SHALL shift (or advance its pointer) only on cycles with in_valid=1.
REQ-018 Inputs SHALL be sign-extended to WIDTH+1 bits before any use.
REQ-019 Phase 0 behaviour:
  - the sign-extended input is written to the delay line;
  - the oldest delay-line entry is routed to the output register.
REQ-020 Phase 1 behaviour, with a = oldest delay-line entry and b = input:
  - output register receives a+b;
  - delay line is written with a-b;
  - all arithmetic is (WIDTH+1)-bit two's complement with no saturation.
REQ-021 When SCALE=1, every value loaded into the output register (sum and passed-through difference alike) SHALL be arithmetically shifted right by 1 (truncation toward -inf), with the sign retained in WIDTH+1 bits.
REQ-022 Latency SHALL be one clk cycle: out_valid(t+1) = in_valid(t); out_re/out_im update only when in_valid=1 and hold otherwise.
REQ-023 out_sof SHALL be 1 for exactly the output cycle carrying the sum computed at effective count D; otherwise 0.
REQ-024 Stalls (in_valid=0) SHALL neither change any state nor create bubbles in the data ordering; results SHALL be independent of the stall pattern.
REQ-025 Differences of the final frame SHALL emerge only when D further valid samples are supplied (for example, zeros).

Reset
REQ-026 While rst=1, and immediately on its assertion (including mid-frame), the following SHALL be cleared:
  - out_valid=0, out_sof=0, out_re=0, out_im=0;
  - cnt=0;
  - all delay-line entries = 0.
REQ-027 The first valid input after rst deasserts SHALL be treated as effective count 0, whether or not in_sof is asserted.

Verification (WIDTH=13, DEPTH_LOG2=3)
REQ-028 Reset: assert rst mid-frame with in_valid=1. Required response:
  - out_valid, out_sof, out_re, out_im all 0 in the same cycle;
  - after release, the first 8 outputs are 0.
REQ-029 Ramp: in_re=n for n=0..15, then 8 zeros, continuous valid, in_im=0. Required response:
  - outputs 0 x8;
  - then 8,10,...,22 with out_sof on the 8;
  - then -8 x8.
REQ-030 Extremes: all 16 inputs = 4095, then all 16 = -4096. Required response:
  - sums 8190;
  - following differences 0;
  - sums -8192 for the second frame.
REQ-031 Stalls: repeat REQ-029 with in_valid toggling 1,0,1,0. Required response:
  - identical value sequence;
  - out_valid equals in_valid delayed 1 cycle.
REQ-032 SCALE=1: repeat REQ-029. Required response:
  - sums 4,5,...,11;
  - differences -4;
  - additionally, x0=-1 and x8=0 gives sum output -1.
REQ-033 Resync: assert in_sof at the 6th sample of a frame. Required response: out_sof appears on the output of the 8th valid sample after it.

Source files
------------

// File: rtl/sdf_bf_stage.sv
// Radix-2 single-path delay-feedback (SDF) butterfly stage.
// Each 2D-sample frame splits into two halves. During the first half the
// input is parked in a D-deep feedback delay line, and the previous frame's
// differences drain out. During the second half the parked sample a meets
// the new sample b. a+b goes to the output and a-b is fed back into the delay
// line. Arithmetic is done in WIDTH+1 bits so the butterfly growth bit is kept.
module sdf_bf_stage #(
    parameter int WIDTH      = 13,
    parameter int DEPTH_LOG2 = 3,
    parameter int SCALE      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    output logic             out_sof,
    output logic [WIDTH:0]   out_re,
    output logic [WIDTH:0]   out_im
);

    localparam int D  = 1 << DEPTH_LOG2;
    localparam int OW = WIDTH + 1;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] HALF_C = CW'(D);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] ZERO_C = CW'(0);

    // Optional divide-by-two on every value that reaches the output register.
    // An arithmetic shift keeps the sign and truncates toward -inf.
    function automatic logic [OW-1:0] scale_f(input logic [OW-1:0] v);
        logic [OW-1:0] r;
        if (SCALE != 0) begin
            r = {v[OW-1], v[OW-1:1]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] eff_cnt_s;
    logic          phase_s;
    logic [OW-1:0] dl_re_q [D];
    logic [OW-1:0] dl_im_q [D];
    logic [OW-1:0] ext_re_s, ext_im_s;
    logic [OW-1:0] old_re_s, old_im_s;
    logic [OW-1:0] dl_in_re_d, dl_in_im_d;
    logic [OW-1:0] out_re_d, out_im_d;
    logic          out_sof_d;
    logic          out_valid_q, out_sof_q;
    logic [OW-1:0] out_re_q, out_im_q;

    assign ext_re_s = {in_re[WIDTH-1], in_re};
    assign ext_im_s = {in_im[WIDTH-1], in_im};
    assign old_re_s = dl_re_q[D-1];
    assign old_im_s = dl_im_q[D-1];

    // Frame position. A start-of-frame resynchronises this sample to position 0.
    always_comb begin
        eff_cnt_s = cnt_q;
        if (in_valid && in_sof) begin
            eff_cnt_s = ZERO_C;
        end else begin
            eff_cnt_s = cnt_q;
        end
        phase_s = eff_cnt_s[CW-1];
        cnt_d   = eff_cnt_s + ONE_C;
    end

    // Butterfly datapath: first half parks the input, second half adds and subtracts.
    always_comb begin
        dl_in_re_d = ext_re_s;
        dl_in_im_d = ext_im_s;
        out_re_d   = scale_f(old_re_s);
        out_im_d   = scale_f(old_im_s);
        if (phase_s) begin
            dl_in_re_d = old_re_s - ext_re_s;
            dl_in_im_d = old_im_s - ext_im_s;
            out_re_d   = scale_f(old_re_s + ext_re_s);
            out_im_d   = scale_f(old_im_s + ext_im_s);
        end else begin
            dl_in_re_d = ext_re_s;
            dl_in_im_d = ext_im_s;
            out_re_d   = scale_f(old_re_s);
            out_im_d   = scale_f(old_im_s);
        end
        out_sof_d = in_valid && (eff_cnt_s == HALF_C);
    end

    // Sample counter advances only on valid samples, so stalls leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= ZERO_C;
        end else if (in_valid) begin
            cnt_q <= cnt_d;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Feedback delay line shifts one place per valid sample. Entry D-1 is the oldest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else if (in_valid) begin
            dl_re_q[0] <= dl_in_re_d;
            dl_im_q[0] <= dl_in_im_d;
            for (int i = 1; i < D; i++) begin
                dl_re_q[i] <= dl_re_q[i-1];
                dl_im_q[i] <= dl_im_q[i-1];
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                dl_re_q[i] <= dl_re_q[i];
                dl_im_q[i] <= dl_im_q[i];
            end
        end
    end

    // Output register: valid/sof follow the input by one cycle, data holds across stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            out_valid_q <= in_valid;
            out_sof_q   <= out_sof_d;
            if (in_valid) begin
                out_re_q <= out_re_d;
                out_im_q <= out_im_d;
            end else begin
                out_re_q <= out_re_q;
                out_im_q <= out_im_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage (WIDTH=13, DEPTH_LOG2=3).
// u0 uses the full-precision output. u1 uses the halved output.
// Both instances receive the same stimulus.
module tb_sdf_bf_stage;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_sof;
    logic [12:0]        in_re;
    logic [12:0]        in_im;
    logic               o0_valid, o0_sof, o1_valid, o1_sof;
    logic signed [13:0] o0_re, o0_im, o1_re, o1_im;

    int total;
    int bad;

    sdf_bf_stage #(.WIDTH(13), .DEPTH_LOG2(3), .SCALE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im),
        .out_valid(o0_valid), .out_sof(o0_sof), .out_re(o0_re), .out_im(o0_im)
    );

    sdf_bf_stage #(.WIDTH(13), .DEPTH_LOG2(3), .SCALE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im),
        .out_valid(o1_valid), .out_sof(o1_sof), .out_re(o1_re), .out_im(o1_im)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [15:0] obs,
                       input logic signed [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one input cycle, then sample just after the rising edge.
    task automatic step(input logic v, input logic s, input int re, input int im);
        in_valid = v;
        in_sof   = s;
        in_re    = re[12:0];
        in_im    = im[12:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0, e1, ere, eim;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = 13'd0;
        in_im    = 13'd0;
        #21;
        chk("rst_valid", 16'(o0_valid), 16'sd0);
        chk("rst_sof",   16'(o0_sof),   16'sd0);
        chk("rst_re",    o0_re,         16'sd0);
        chk("rst_im",    o0_im,         16'sd0);
        rst = 1'b0;

        // Ramp 0..15, then 8 zeros to flush the differences.
        for (int n = 0; n < 24; n++) begin
            step(1'b1, n == 0, (n < 16) ? n : 0, 0);
            e0 = (n < 8) ? 0 : (n < 16) ? (2 * n - 8) : -8;
            e1 = (n < 8) ? 0 : (n < 16) ? (n - 4) : -4;
            chk($sformatf("ramp_re[%0d]", n), o0_re, 16'(e0));
            chk($sformatf("ramp_s1_re[%0d]", n), o1_re, 16'(e1));
            chk($sformatf("ramp_sof[%0d]", n), 16'(o0_sof), 16'(n == 8));
            chk($sformatf("ramp_valid[%0d]", n), 16'(o0_valid), 16'sd1);
            chk($sformatf("ramp_im[%0d]", n), o0_im, 16'sd0);
        end

        // Extremes: +max/-min frame, then -min/+max frame.
        for (int n = 0; n < 32; n++) begin
            step(1'b1, (n == 0) || (n == 16), (n < 16) ? 4095 : -4096,
                 (n < 16) ? -4096 : 4095);
            ere = (n < 8) ? 0 : (n < 16) ? 8190 : (n < 24) ? 0 : -8192;
            eim = (n < 8) ? 0 : (n < 16) ? -8192 : (n < 24) ? 0 : 8190;
            chk($sformatf("ext_re[%0d]", n), o0_re, 16'(ere));
            chk($sformatf("ext_im[%0d]", n), o0_im, 16'(eim));
        end

        // Ramp again with a stall after every sample. Stall cycles carry junk and in_sof=1.
        for (int n = 0; n < 24; n++) begin
            step(1'b1, n == 0, (n < 16) ? n : 0, 0);
            e0 = (n < 8) ? 0 : (n < 16) ? (2 * n - 8) : -8;
            chk($sformatf("stall_re[%0d]", n), o0_re, 16'(e0));
            chk($sformatf("stall_valid[%0d]", n), 16'(o0_valid), 16'sd1);
            chk($sformatf("stall_sof[%0d]", n), 16'(o0_sof), 16'(n == 8));
            step(1'b0, 1'b1, 1234, -77);
            chk($sformatf("stall_hold[%0d]", n), o0_re, 16'(e0));
            chk($sformatf("stall_nvalid[%0d]", n), 16'(o0_valid), 16'sd0);
            chk($sformatf("stall_nsof[%0d]", n), 16'(o0_sof), 16'sd0);
        end

        // Halved sum of -1 and 0 rounds toward -inf.
        for (int n = 0; n < 9; n++) begin
            step(1'b1, n == 0, (n == 0) ? -1 : 0, 0);
        end
        chk("neg_s1_sum", o1_re, -16'sd1);
        chk("neg_s0_sum", o0_re, -16'sd1);

        // Resync: sof on the 6th sample of a frame, values k+1.
        for (int k = 0; k < 14; k++) begin
            step(1'b1, (k == 0) || (k == 5), k + 1, 0);
            chk($sformatf("resync_sof[%0d]", k), 16'(o0_sof), 16'(k == 13));
        end
        chk("resync_sum", o0_re, 16'sd20);

        // Mid-frame asynchronous reset with valid input held high.
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_re    = 13'd100;
        in_im    = 13'd100;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 16'(o0_valid), 16'sd0);
        chk("arst_sof",   16'(o0_sof),   16'sd0);
        chk("arst_re",    o0_re,         16'sd0);
        chk("arst_im",    o0_im,         16'sd0);
        chk("arst_s1_re", o1_re,         16'sd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 1'b0, 5, 5);
            chk($sformatf("post_rst_re[%0d]", n), o0_re, 16'sd0);
            chk($sformatf("post_rst_sof[%0d]", n), 16'(o0_sof), 16'sd0);
        end
        step(1'b1, 1'b0, 5, 5);
        chk("post_rst_sum", o0_re, 16'sd10);
        chk("post_rst_sum_sof", 16'(o0_sof), 16'sd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
